// File: rtl/cv32e41s_pkg.sv
// Shared types and limits for the PC hardening sequencing controller.
package cv32e41s_pkg;

    typedef enum logic [1:0] {
        PC_HW_OFF   = 2'd0,
        PC_HW_FLUSH = 2'd1,
        PC_HW_ARM   = 2'd2,
        PC_HW_ON    = 2'd3
    } pc_hw_state_e;

    localparam int unsigned PC_HW_ARM_MAX   = 15;
    localparam int unsigned PC_HW_ARM_CNT_W = $clog2(PC_HW_ARM_MAX + 1);

endpackage

// File: rtl/cv32e41s_sat_counter.sv
// Saturating event counter; an increment together with a clear restarts the count at one.
module cv32e41s_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (i_clr) begin
                r_cnt <= WIDTH'(1);
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cv32e41s_pc_hardening_ctrl.sv
// Flush-then-arm sequencer for the PC checker, plus error event qualification.
// Optional error counter is built only when CV32E41S_PC_ERR_CNT_EN is defined.
module cv32e41s_pc_hardening_ctrl
    import cv32e41s_pkg::*;
#(
    parameter int unsigned ARM_CYCLES = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpuctrl_we_i,
    input  logic                 cpuctrl_pc_hardening_i,
    output logic                 flush_req_o,
    input  logic                 flush_ack_i,
    output logic                 pc_hardening_en_o,
    input  logic                 pc_err_i,
    input  logic                 err_clr_i,
    output logic                 alert_major_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [1:0]           state_o
);

    localparam logic [PC_HW_ARM_CNT_W-1:0] ARM_LOAD = PC_HW_ARM_CNT_W'(ARM_CYCLES - 1);

    pc_hw_state_e                r_state;
    pc_hw_state_e                w_state_next;
    logic                        r_target;
    logic                        w_target_next;
    logic [PC_HW_ARM_CNT_W-1:0]  r_arm_cnt;
    logic [PC_HW_ARM_CNT_W-1:0]  w_arm_cnt_next;
    logic                        r_pc_err;
    logic                        r_alert;
    logic                        r_sticky;
    logic                        w_qerr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PC_HW_OFF;
            r_target  <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_target  <= w_target_next;
            r_arm_cnt <= w_arm_cnt_next;
        end
    end

    // A write in the same cycle as the ack updates the target before the ack resolves.
    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_arm_cnt_next = r_arm_cnt;
        if (cpuctrl_we_i) begin
            w_target_next = cpuctrl_pc_hardening_i;
        end
        unique case (r_state)
            PC_HW_OFF: begin
                if (cpuctrl_we_i && cpuctrl_pc_hardening_i) begin
                    w_state_next = PC_HW_FLUSH;
                end
            end
            PC_HW_FLUSH: begin
                if (flush_ack_i) begin
                    if (w_target_next) begin
                        w_state_next   = PC_HW_ARM;
                        w_arm_cnt_next = ARM_LOAD;
                    end else begin
                        w_state_next = PC_HW_OFF;
                    end
                end
            end
            PC_HW_ARM: begin
                if (cpuctrl_we_i && !cpuctrl_pc_hardening_i) begin
                    w_state_next = PC_HW_FLUSH;
                end else if (r_arm_cnt == '0) begin
                    w_state_next = PC_HW_ON;
                end else begin
                    w_arm_cnt_next = r_arm_cnt - 1'b1;
                end
            end
            PC_HW_ON: begin
                if (cpuctrl_we_i && !cpuctrl_pc_hardening_i) begin
                    w_state_next = PC_HW_FLUSH;
                end
            end
            default: begin
                w_state_next = PC_HW_OFF;
            end
        endcase
    end

    assign w_qerr = (r_state == PC_HW_ON) && pc_err_i && !r_pc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_err <= 1'b0;
            r_alert  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_pc_err <= pc_err_i;
            r_alert  <= w_qerr;
            if (w_qerr) begin
                r_sticky <= 1'b1;
            end else if (err_clr_i) begin
                r_sticky <= 1'b0;
            end
        end
    end

`ifdef CV32E41S_PC_ERR_CNT_EN
    cv32e41s_sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_qerr),
        .i_clr (err_clr_i),
        .o_cnt (err_cnt_o)
    );
`else
    assign err_cnt_o = '0;
`endif

    assign flush_req_o       = (r_state == PC_HW_FLUSH);
    assign pc_hardening_en_o = ((r_state == PC_HW_FLUSH) && r_target) ||
                               (r_state == PC_HW_ARM) || (r_state == PC_HW_ON);
    assign alert_major_o     = r_alert;
    assign err_sticky_o      = r_sticky;
    assign state_o           = r_state;

endmodule

// File: doc/cv32e41s_pc_hardening_ctrl.md
# cv32e41s_pc_hardening_ctrl

Sequencing controller for the PC hardening checker. It turns cpuctrl.pc_hardening CSR writes into a flush-then-arm sequence: request a pipeline flush, drive the checker enable, and mask checker errors for a programmable settling window. Once checking is live, it converts checker error levels into single alert events, a sticky flag and a saturating event count. It sits in the core top-level, between the CSR/controller logic and the PC checker.

## Interface
Parameters:
- ARM_CYCLES, default 2: cycles after flush acknowledge during which checker errors are masked; legal range 1..15.
- ERR_CNT_W, default 8: width of the error event counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cpuctrl_we_i  in  1  cpuctrl CSR write retiring in WB this cycle
- cpuctrl_pc_hardening_i  in  1  pc_hardening bit value being written
- flush_req_o  out  1  request to controller: flush pipeline and refetch from WB PC+4
- flush_ack_i  in  1  controller performed the requested flush/pc_set this cycle
- pc_hardening_en_o  out  1  enable to PC checker
- pc_err_i  in  1  raw error level from PC checker
- err_clr_i  in  1  clear sticky flag and counter
- alert_major_o  out  1  one-cycle pulse per qualified error event
- err_sticky_o  out  1  set by any qualified event
- err_cnt_o  out  ERR_CNT_W  saturating qualified event count
- state_o  out  2  current FSM state, for observation

## Operation
- States, encoded OFF=0, FLUSH=1, ARM=2, ON=3:
  - OFF: no flush request, enable low, errors ignored.
  - FLUSH: flush_req_o=1; pc_hardening_en_o=target_q.
  - ARM: flush_req_o=0; enable=1; errors masked.
  - ON: flush_req_o=0; enable=1; errors qualified.
- target_q holds the last written pc_hardening value.
- Transitions on cpuctrl_we_i:
  - In OFF, a write of 1 goes to FLUSH with target=1. A write of 0 stays in OFF.
  - In ARM or ON, a write of 0 goes to FLUSH with target=0. A write of 1 restarts nothing and stays in the current state.
  - In FLUSH, a write updates target_q and stays in FLUSH; flush_req_o remains high.
- Transitions on flush_ack_i:
  - In FLUSH, flush_ack_i goes to ARM if target_q=1, otherwise to OFF. The ARM counter loads ARM_CYCLES-1.
  - flush_ack_i outside FLUSH is ignored.
- If cpuctrl_we_i and flush_ack_i arrive in the same cycle in FLUSH, the write updates target first, then the ack resolves against the new target.
- In ARM, the counter decrements each cycle. When it reaches 0, the next state is ON. A write of 0 during ARM aborts to FLUSH.
- Qualified error: qerr = (state==ON) && pc_err_i && !pc_err_q, where pc_err_q is pc_err_i registered every cycle. A persistent error level therefore produces exactly one event.
- Each qualified error does three things:
  - alert_major_o pulses in the next cycle.
  - err_sticky_o is set.
  - err_cnt_o increments, saturating at all-ones with no wrap.
- err_clr_i clears err_sticky_o and err_cnt_o. If a qualified error occurs in the same cycle, the event wins: sticky=1, count=1. err_clr_i does not affect the FSM.

## Timing
- Reset values: state OFF, target_q=0, flush_req_o=0, pc_hardening_en_o=0, alert_major_o=0, err_sticky_o=0, err_cnt_o=0, pc_err_q=0.
- All outputs are registered or decoded from registered state.
- A write takes effect on state the next cycle, so flush_req_o rises one cycle after cpuctrl_we_i.
- Enable rises in the cycle after the write of 1, i.e. in FLUSH with target=1.
- The first cycle an error can be qualified is ARM_CYCLES cycles after the cycle following flush_ack_i.
- Alert latency is 1 cycle from the pc_err_i rising edge observed in ON.
- Disable: enable drops the cycle after the write of 0. Errors are unqualified from that cycle on, because the state is no longer ON.
- There is no timeout on flush_ack_i; the FSM waits in FLUSH indefinitely.

## Configuration
- CV32E41S_PC_ERR_CNT_EN:
  - Defined: the counter is implemented as specified.
  - Undefined: no counter flops; err_cnt_o is tied to 0. Sticky and alert behaviour is unchanged.

## Structure
- Shared package cv32e41s_pkg contains:
  - enum pc_hw_state_e {PC_HW_OFF, PC_HW_FLUSH, PC_HW_ARM, PC_HW_ON}, 2 bits.
  - constant PC_HW_ARM_MAX=15.
- Sub-module cv32e41s_sat_counter, parameterized width, with inc/clr inputs where inc has priority, holds the error counter. It is instantiated only under CV32E41S_PC_ERR_CNT_EN.

## Test plan
- Enable sequence: write 1 → flush_req_o=1 next cycle. Ack 3 cycles later → ARM. With ARM_CYCLES=2, state_o=3 two cycles after the ack cycle+1, and enable=1 throughout.
- Masking: pc_err_i=1 during FLUSH and ARM → alert_major_o=0 and err_cnt_o=0. Hold pc_err_i high into ON → no event, since no rising edge.
- Event: in ON, pc_err_i pulses 1 cycle, three times → three alert pulses, each 1 cycle after its pulse; err_cnt_o=3; err_sticky_o=1. pc_err_i held 10 cycles → exactly one event.
- Saturation: ERR_CNT_W=2, five events → err_cnt_o=3. Then err_clr_i together with an event → err_cnt_o=1, sticky=1.
- Retarget: write 1, then write 0 while in FLUSH, then ack → state OFF, enable=0, flush_req_o=0.
- Reset mid-ARM: assert rst_n low during ARM → all outputs return to reset values asynchronously; state_o=0.
